// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and state typedefs used by the InvMixColumns datapath.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [31:0]  column_t;
    typedef logic [127:0] state_t;

    typedef enum logic [7:0] {
        MUL_09 = 8'h09,
        MUL_0B = 8'h0B,
        MUL_0D = 8'h0D,
        MUL_0E = 8'h0E
    } inv_coef_e;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    // Constant multipliers built from x, x2, x4, x8 so each reduces to an XOR tree.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input inv_coef_e k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] res;
        x2  = xtime(x);
        x4  = xtime(x2);
        x8  = xtime(x4);
        res = x8 ^ x4 ^ x2;
        case (k)
            MUL_09:  res = x8 ^ x;
            MUL_0B:  res = x8 ^ x2 ^ x;
            MUL_0D:  res = x8 ^ x4 ^ x;
            default: res = x8 ^ x4 ^ x2;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/inv_mix_columns_if.sv
// State bus between the round datapath and the InvMixColumns stage.
interface inv_mix_columns_if;
    import aes_pkg::*;

    state_t state_in;
    state_t state_out;

    modport master (output state_in, input  state_out);
    modport slave  (input  state_in, output state_out);

endinterface

// File: rtl/inv_mix_single_column.sv
// One 32-bit column of InvMixColumns; purely combinational.
module inv_mix_single_column
    import aes_pkg::*;
(
    input  column_t col_i,
    output column_t col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign col_o[31:24] = gf_mul(a0, MUL_0E) ^ gf_mul(a1, MUL_0B) ^ gf_mul(a2, MUL_0D) ^ gf_mul(a3, MUL_09);
    assign col_o[23:16] = gf_mul(a0, MUL_09) ^ gf_mul(a1, MUL_0E) ^ gf_mul(a2, MUL_0B) ^ gf_mul(a3, MUL_0D);
    assign col_o[15:8]  = gf_mul(a0, MUL_0D) ^ gf_mul(a1, MUL_09) ^ gf_mul(a2, MUL_0E) ^ gf_mul(a3, MUL_0B);
    assign col_o[7:0]   = gf_mul(a0, MUL_0B) ^ gf_mul(a1, MUL_0D) ^ gf_mul(a2, MUL_09) ^ gf_mul(a3, MUL_0E);

endmodule

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns stage: four independent column mixers feeding one 128-bit register.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    inv_mix_columns_if.slave  bus
);

    state_t state_d;
    state_t state_q;

    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_single_column u_col (
            .col_i (bus.state_in[127-32*c -: 32]),
            .col_o (state_d[127-32*c -: 32])
        );
    end

    // NOTE: non-blocking assignment keeps the register update race-free against other clocked readers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.state_out = state_q;

endmodule

// File: tb/tb_inv_mix_columns.sv
// Self-checking bench for inv_mix_columns: fixed vectors, streaming, reset cases and random checks.
module tb_inv_mix_columns;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    inv_mix_columns_if bus ();

    inv_mix_columns dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] stim;
        logic [127:0] expect_out;
    } vec_t;

    // Generic shift-and-add multiply in GF(2^8), independent of the RTL's constant multipliers.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = {aa[6:0], 1'b0};
            if (hi) aa = aa ^ 8'h1B;
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Circulant matrix product per column; coefs holds the first matrix row, MSB first.
    function automatic logic [127:0] circ_mul(input logic [127:0] s, input logic [31:0] coefs);
        logic [127:0] r;
        logic [7:0]   acc;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int i = 0; i < 4; i++) begin
                    acc = acc ^ gmul(s[127-32*c-8*i -: 8], coefs[31-8*((i-row+4)%4) -: 8]);
                end
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        return circ_mul(s, 32'h0E0B0D09);
    endfunction

    function automatic logic [127:0] ref_fwd(input logic [127:0] s);
        return circ_mul(s, 32'h02030101);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t         vecs[6];
    logic [127:0] prev_in;
    logic [127:0] stream[3];
    logic [127:0] rnd;

    initial begin
        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 128'hdb135345_f20a225c_01010101_2d26314c};
        vecs[1] = '{128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6, 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6};
        vecs[2] = '{128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6, 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5};
        vecs[3] = '{128'h0, 128'h0};
        vecs[4] = '{{128{1'b1}}, {128{1'b1}}};
        vecs[5] = '{128'h01000000_00000000_00000000_00000000, 128'h0e090d0b_00000000_00000000_00000000};

        // Reset held two cycles with all-ones input.
        reset        = 1'b1;
        bus.state_in = {128{1'b1}};
        tick();
        check("reset_cycle0", bus.state_out, 128'h0);
        tick();
        check("reset_cycle1", bus.state_out, 128'h0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            bus.state_in = vecs[i].stim;
            tick();
            check($sformatf("table_%0d", i), bus.state_out, vecs[i].expect_out);
        end

        // Back-to-back streaming, one new state per clock.
        stream[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
        stream[1] = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        stream[2] = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
        for (int i = 0; i < 3; i++) begin
            bus.state_in = stream[i];
            tick();
            check($sformatf("stream_%0d", i), bus.state_out, ref_inv(stream[i]));
        end

        // Reset for a single edge between two vectors.
        bus.state_in = stream[0];
        tick();
        check("mid_pre", bus.state_out, ref_inv(stream[0]));
        reset        = 1'b1;
        bus.state_in = stream[1];
        tick();
        check("mid_reset", bus.state_out, 128'h0);
        reset = 1'b0;
        tick();
        check("mid_post", bus.state_out, ref_inv(stream[1]));

        // Random vectors: forward MixColumns must undo the stage, and the reference must agree.
        prev_in = stream[1];
        for (int i = 0; i < 1000; i++) begin
            rnd          = {$urandom, $urandom, $urandom, $urandom};
            bus.state_in = rnd;
            tick();
            check("rand_roundtrip", ref_fwd(bus.state_out), rnd);
            check("rand_ref", bus.state_out, ref_inv(rnd));
            prev_in = rnd;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
